// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser and glitch filter feeding
// mode-selected edge pulses, sticky event flags and a saturating event counter.
module edge_detect_multi #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   din,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    input  logic                  count_clr,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse,
    output logic                  any_pulse,
    output logic [CHANNELS-1:0]   sticky,
    output logic [CNT_W-1:0]      evt_count
);

    localparam int FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int POP_W  = $clog2(CHANNELS + 1);
    localparam int SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    function automatic logic [POP_W-1:0] popcount(input logic [CHANNELS-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // Sum is formed one bit wider than either operand so the clamp never sees a wrap.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] res;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > SUM_W'(CNT_MAX)) begin
            res = CNT_MAX;
        end else begin
            res = sum[CNT_W-1:0];
        end
        return res;
    endfunction

    logic [CHANNELS-1:0] sync_p [SYNC_STAGES];
    logic [CHANNELS-1:0] s;
    logic [FCNT_W-1:0]   fcnt_q [CHANNELS];
    logic [FCNT_W-1:0]   fcnt_d [CHANNELS];
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] pulse_d;
    logic [CHANNELS-1:0] sticky_d;
    logic [POP_W-1:0]    pop_d;
    logic [CNT_W-1:0]    count_d;

    // Synchroniser stage: SYNC_STAGES flops per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_p[k] <= '0;
            end
        end else begin
            sync_p[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_p[k] <= sync_p[k-1];
            end
        end
    end

    assign s = sync_p[SYNC_STAGES-1];

    always_comb begin
        level_d = level;
        pulse_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            fcnt_d[i] = '0;
            if (s[i] != level[i]) begin
                if (fcnt_q[i] == FCNT_LAST) begin
                    level_d[i] = s[i];
                    pulse_d[i] = s[i] ? mode[2*i] : mode[2*i+1];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
                end
            end
        end
    end

    // Filter / edge stage: level, pulse and the filter counters move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level     <= '0;
            pulse     <= '0;
            any_pulse <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            level     <= level_d;
            pulse     <= pulse_d;
            any_pulse <= |pulse_d;
            for (int i = 0; i < CHANNELS; i++) begin
                fcnt_q[i] <= fcnt_d[i];
            end
        end
    end

    // Set is ORed in after the clear so a coincident pulse keeps the flag.
    assign sticky_d = (sticky & ~clr) | pulse_d;
    assign pop_d    = popcount(pulse_d);
    assign count_d  = count_clr ? sat_add(CNT_W'(0), pop_d) : sat_add(evt_count, pop_d);

    // Event stage: sticky flags and global counter, aligned with pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky    <= '0;
            evt_count <= '0;
        end else begin
            sticky    <= sticky_d;
            evt_count <= count_d;
        end
    end

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: a cycle model pushes expected outputs per
// edge into a scoreboard queue, popped and compared after each edge.
module tb_edge_detect_multi;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int FC = 3;
    localparam int CW = 4;
    localparam int HL = SS + FC - 1;

    logic          clk;
    logic          rst_n;
    logic [CH-1:0] din;
    logic [2*CH-1:0] mode;
    logic [CH-1:0] clr;
    logic          count_clr;
    logic [CH-1:0] level;
    logic [CH-1:0] pulse;
    logic          any_pulse;
    logic [CH-1:0] sticky;
    logic [CW-1:0] evt_count;

    edge_detect_multi #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .clr(clr),
        .count_clr(count_clr), .level(level), .pulse(pulse),
        .any_pulse(any_pulse), .sticky(sticky), .evt_count(evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] lvl;
        logic [CH-1:0] pls;
        logic          anyp;
        logic [CH-1:0] stk;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    // Model state: hist[c][j] is din[c] as sampled j+1 edges ago.
    logic [HL-1:0] hist [CH];
    logic [CH-1:0] m_level;
    logic [CH-1:0] m_sticky;
    logic [CW-1:0] m_cnt;
    int            pc [CH];
    int            l2_toggles = 0;
    logic          l2_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [CW-1:0] msat(input int v);
        int lim;
        lim = (1 << CW) - 1;
        return (v > lim) ? CW'(lim) : CW'(v);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) hist[c] = '0;
        m_level  = '0;
        m_sticky = '0;
        m_cnt    = '0;
    endtask

    // A level change needs FC consecutive synchronised samples differing from it.
    task automatic cyc();
        exp_t e;
        exp_t ef;
        logic [CH-1:0] p;
        logic upd;
        logic sv;
        p = '0;
        if (rst_n) begin
            for (int c = 0; c < CH; c++) begin
                sv  = hist[c][SS-1];
                upd = 1'b1;
                for (int j = SS - 1; j < HL; j++) begin
                    if (hist[c][j] == m_level[c]) upd = 1'b0;
                end
                if (upd) begin
                    m_level[c] = sv;
                    p[c] = sv ? mode[2*c] : mode[2*c+1];
                end
                hist[c] = {hist[c][HL-2:0], din[c]};
            end
            m_sticky = (m_sticky & ~clr) | p;
            m_cnt = count_clr ? msat($countones(p)) : msat(int'(m_cnt) + $countones(p));
        end
        e.lvl  = m_level;
        e.pls  = p;
        e.anyp = |p;
        e.stk  = m_sticky;
        e.cnt  = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ef = sb.pop_front();
        chk("level", 32'(level), 32'(ef.lvl));
        chk("pulse", 32'(pulse), 32'(ef.pls));
        chk("any_pulse", 32'(any_pulse), 32'(ef.anyp));
        chk("sticky", 32'(sticky), 32'(ef.stk));
        chk("evt_count", 32'(evt_count), 32'(ef.cnt));
        for (int c = 0; c < CH; c++) pc[c] += int'(pulse[c]);
        if (level[2] !== l2_prev) l2_toggles++;
        l2_prev = level[2];
    endtask

    task automatic cycn(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic square(input int c, input int half, input int periods);
        for (int p = 0; p < periods; p++) begin
            din[c] = 1'b1;
            cycn(half);
            din[c] = 1'b0;
            cycn(half);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_pulse"}, 32'(pulse), 32'd0);
        chk({tag, "_any"}, 32'(any_pulse), 32'd0);
        chk({tag, "_sticky"}, 32'(sticky), 32'd0);
        chk({tag, "_count"}, 32'(evt_count), 32'd0);
    endtask

    initial begin
        for (int c = 0; c < CH; c++) pc[c] = 0;
        rst_n = 1'b0; din = '0; mode = '0; clr = '0; count_clr = 1'b0;
        model_reset();
        #1;
        chk_all_zero("reset");
        cycn(2);
        rst_n = 1'b1;

        // 1: rising edge on ch0, mode 01; pulse on the 5th edge sampling din=1
        mode = 8'b11_11_11_01;
        din[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k < 5) chk("t1_early_pulse", 32'(pulse[0]), 32'd0);
        end
        chk("t1_pulse", 32'(pulse[0]), 32'd1);
        chk("t1_level", 32'(level[0]), 32'd1);
        chk("t1_any", 32'(any_pulse), 32'd1);
        cyc();
        chk("t1_pulse_width", 32'(pulse[0]), 32'd0);
        chk("t1_sticky", 32'(sticky[0]), 32'd1);
        chk("t1_count", 32'(evt_count), 32'd1);

        // 2: glitch of 2 cycles rejected, 3 cycles accepted (rise then fall)
        pc[1] = 0;
        din[1] = 1'b1; cycn(2);
        din[1] = 1'b0; cycn(6);
        chk("t2_glitch_level", 32'(level[1]), 32'd0);
        chk("t2_glitch_pulses", 32'(pc[1]), 32'd0);
        chk("t2_glitch_count", 32'(evt_count), 32'd1);
        din[1] = 1'b1; cycn(3);
        din[1] = 1'b0; cycn(8);
        chk("t2_held_pulses", 32'(pc[1]), 32'd2);
        chk("t2_held_count", 32'(evt_count), 32'd3);

        // 3: ch2 square wave 8/8 under modes 11, 10, 00
        pc[2] = 0;
        square(2, 8, 2);
        chk("t3_mode11", 32'(pc[2]), 32'd4);
        mode[5:4] = 2'b10;
        pc[2] = 0;
        square(2, 8, 2);
        chk("t3_mode10", 32'(pc[2]), 32'd2);
        mode[5:4] = 2'b00;
        pc[2] = 0;
        l2_toggles = 0;
        square(2, 8, 2);
        chk("t3_mode00_pulses", 32'(pc[2]), 32'd0);
        chk("t3_mode00_toggles", 32'(l2_toggles), 32'd4);
        chk("t3_count", 32'(evt_count), 32'd9);

        // 4: clear coincident with a new pulse keeps sticky; clear alone drops it
        din[0] = 1'b0; cycn(8);
        chk("t4_sticky_kept", 32'(sticky[0]), 32'd1);
        din[0] = 1'b1; cycn(4);
        clr[0] = 1'b1;
        cyc();
        chk("t4_pulse", 32'(pulse[0]), 32'd1);
        chk("t4_set_wins", 32'(sticky[0]), 32'd1);
        cyc();
        chk("t4_cleared", 32'(sticky[0]), 32'd0);
        clr[0] = 1'b0;

        // 5: saturation, clear, multi-channel add, clear coincident with pulses
        count_clr = 1'b1; cyc(); count_clr = 1'b0;
        chk("t5_clr", 32'(evt_count), 32'd0);
        pc[3] = 0;
        square(3, 6, 10);
        cycn(8);
        chk("t5_pulses", 32'(pc[3]), 32'd20);
        chk("t5_sat", 32'(evt_count), 32'd15);
        cycn(10);
        chk("t5_sat_hold", 32'(evt_count), 32'd15);
        mode = 8'hFF;
        din[0] = 1'b0; cycn(8);
        count_clr = 1'b1; cyc(); count_clr = 1'b0;
        chk("t5_clr2", 32'(evt_count), 32'd0);
        din[0] = 1'b1; din[1] = 1'b1; din[3] = 1'b1;
        cycn(5);
        chk("t5_multi_pulse", 32'(pulse), 32'b1011);
        chk("t5_multi_count", 32'(evt_count), 32'd3);
        cycn(3);
        din[0] = 1'b0; din[1] = 1'b0;
        cycn(4);
        count_clr = 1'b1; cyc(); count_clr = 1'b0;
        chk("t5_clr_pulse", 32'(pulse), 32'b0011);
        chk("t5_clr_load", 32'(evt_count), 32'd2);
        cycn(3);

        // 6: asynchronous reset while ch0 filter counter is mid-count
        din[0] = 1'b1;
        cycn(3);
        #2;
        rst_n = 1'b0;
        din = 4'b0001;
        #1;
        chk_all_zero("t6_async");
        model_reset();
        cycn(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k < 5) chk("t6_early_pulse", 32'(pulse), 32'd0);
        end
        chk("t6_pulse", 32'(pulse), 32'b0001);
        cyc();
        chk("t6_single", 32'(pulse), 32'd0);
        chk("t6_count", 32'(evt_count), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
Parametrised successor to the single-channel posedge detector. It takes CHANNELS asynchronous inputs and passes each through a synchroniser and a glitch filter. Per channel it then emits one-cycle pulses on rising, falling or both edges, selected by a run-time mode. It also holds per-channel sticky event flags with clear and a saturating global event counter. Typical use is the front end for buttons, external strobes and handshake lines feeding control FSMs.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flop depth per channel (>=2)
FILTER_CYCLES, 3, consecutive cycles a new synchronised value must persist before the filtered level changes (>=1; 1 = no filtering)
CNT_W, 8, width of the global event counter (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
din  in  CHANNELS  raw asynchronous inputs
mode  in  2*CHANNELS  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both; synchronous to clk
clr  in  CHANNELS  per-channel sticky clear, synchronous, level-sensitive
count_clr  in  1  synchronous clear of evt_count
level  out  CHANNELS  filtered, synchronised input level
pulse  out  CHANNELS  one-cycle edge pulse per channel
any_pulse  out  1  OR of pulse
sticky  out  CHANNELS  latched event flags
evt_count  out  CNT_W  saturating count of all pulses

Behaviour:
- Reset: clk is the single clock. rst_n is asynchronous and active-low. While rst_n=0, every flop clears immediately: synchroniser stages, filter counters, level, pulse, any_pulse, sticky and evt_count all read 0.
- Synchroniser: din[i] passes through SYNC_STAGES flops. Its output s[i] reflects din one edge per stage later.
- Filter, per channel, with counter fcnt (width clog2(FILTER_CYCLES), min 1 bit), evaluated each edge:
  - if s==level: fcnt<=0.
  - else if fcnt==FILTER_CYCLES-1: level<=s, fcnt<=0 (the "update" event).
  - else: fcnt<=fcnt+1.
- Latency: a din change held stable changes level on edge SYNC_STAGES+FILTER_CYCLES after the first edge that samples it.
- Glitches: a synchronised excursion shorter than FILTER_CYCLES cycles produces no level change and no pulse. fcnt restarts on any return to the current level.
- Pulse generation: pulse is registered and asserted on the same edge as the update event, for exactly one cycle.
  - rising update (level 0->1): pulse if mode is 01 or 11.
  - falling update (level 1->0): pulse if mode is 10 or 11.
  - mode 00: level still tracks the input; no pulse, no sticky set.
- Mode changes take effect at the next edge. A mode change never generates a pulse by itself.
- Reset level is 0, so an input already high at reset release yields a rising pulse after full latency.
- any_pulse is a registered OR of the next-state pulse vector, so it is cycle-aligned with pulse.
- sticky[i]:
  - set on the edge where pulse[i] goes high.
  - cleared on an edge where clr[i]=1.
  - a simultaneous set and clear leaves sticky=1 (set wins).
- evt_count:
  - each edge adds popcount of the next-state pulse vector, so several channels in one cycle add several counts.
  - saturates at 2^CNT_W-1 and never wraps.
  - count_clr=1 loads the popcount of that cycle (0 if none) instead of accumulating.
- Channels are fully independent; no shared state except evt_count.
- Reset asserted mid-filter or mid-pulse aborts everything. After release, behaviour is as from power-on.

Test Plan (CHANNELS=4, SYNC_STAGES=2, FILTER_CYCLES=3, CNT_W=4):
1. Rising edge on mode 01: din[0] goes 0->1 and is held, mode[1:0]=01.
   Required: level[0] and pulse[0] rise on the 5th edge after the first edge sampling din[0]=1; pulse[0] lasts 1 cycle; sticky[0]=1; evt_count=1; any_pulse mirrors pulse[0].
2. Glitch rejection: din[1] high for 2 cycles then low, mode 11.
   Required: level[1] stays 0, no pulse, evt_count unchanged. The same input held for 3 cycles produces one rising pulse, then one falling pulse after it returns low.
3. Mode selection: ch2 gets a square wave, 8 cycles high / 8 cycles low.
   Required: mode 11 gives 2 pulses per period; mode 10 gives only falling pulses; mode 00 gives none, while level[2] still toggles.
4. Sticky clear: clr[0]=1 on the same edge as a new pulse[0].
   Required: sticky[0] remains 1. With clr[0]=1 and no pulse, sticky[0]=0 on the next edge.
5. Counter: drive 20 pulses.
   Required: evt_count=15 and holds. count_clr sets it to 0. Simultaneous pulses on ch0, ch1 and ch3 add 3 in one cycle. count_clr coincident with 2 pulses gives evt_count=2.
6. Reset mid-filter: drop rst_n during fcnt=1 on ch0.
   Required: all outputs 0 immediately, asynchronously. After release with din[0] held high, a single rising pulse appears at full 5-edge latency, not earlier.
